// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed/unsigned multiply and divide unit.
// Produces one result bit per cycle, with an optional single-cycle multiply.
module muldiv_iter #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               cancel_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_sgn;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_fprod;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_accept = (r_state == S_IDLE) & start_i & ~cancel_i;
  assign w_sgn    = ~op_i[0];
  assign w_a_neg  = w_sgn & a_i[WIDTH-1];
  assign w_b_neg  = w_sgn & b_i[WIDTH-1];
  assign w_b_zero = (b_i == '0);
  assign w_a_abs  = w_a_neg ? -a_i : a_i;
  assign w_b_abs  = w_b_neg ? -b_i : b_i;

  // shift-add: r_x is the high half, r_y the multiplier shifting out
  assign w_add   = r_y[0] ? {1'b0, r_m} : '0;
  assign w_sum   = {1'b0, r_x} + w_add;
  assign w_fprod = {{WIDTH{1'b0}}, r_m} * {{WIDTH{1'b0}}, r_y};

  // restoring step: r_x is the remainder, r_y the dividend/quotient
  assign w_shift = {r_x, r_y[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_m};
  assign w_ge    = ~w_diff[WIDTH];

  assign w_prod     = {r_x, r_y};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  assign w_quo      = r_neg_res ? -r_y : r_y;
  assign w_rem      = r_neg_rem ? -r_x : r_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!op_i[1]) begin
            w_next = S_MUL;
          end else if (w_b_zero) begin
            w_next = S_DONE;
          end else begin
            w_next = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (cancel_i) begin
          w_next = S_IDLE;
        end else if (FAST_MUL || r_cnt == CW'(1)) begin
          w_next = S_FIX;
        end
      end
      S_DIV: begin
        if (cancel_i) begin
          w_next = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = cancel_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_o        = (r_state != S_IDLE);
    ready_o       = (r_state == S_DONE);
    div_by_zero_o = (r_state == S_DONE) & r_dbz;
    result_o      = r_result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_m       <= '0;
      r_result  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= CW'(WIDTH);
            r_is_div  <= op_i[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_dbz     <= op_i[1] & w_b_zero;
            r_x       <= '0;
            r_m       <= op_i[1] ? w_b_abs : w_a_abs;
            r_y       <= op_i[1] ? w_a_abs : w_b_abs;
            if (op_i[1] && w_b_zero) begin
              r_result <= {a_i, {WIDTH{1'b1}}};
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt - CW'(1);
          if (FAST_MUL) begin
            r_x <= w_fprod[2*WIDTH-1:WIDTH];
            r_y <= w_fprod[WIDTH-1:0];
          end else begin
            r_x <= w_sum[WIDTH:1];
            r_y <= {w_sum[0], r_y[WIDTH-1:1]};
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt - CW'(1);
          r_x   <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_y   <= {r_y[WIDTH-2:0], w_ge};
        end
        S_FIX: begin
          if (!cancel_i) begin
            r_result <= r_is_div ? {w_rem, w_quo} : w_prod_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed checks of muldiv_iter, shift-add and
// single-cycle multiply variants driven side by side.
module tb_muldiv_iter;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;

  logic        s_busy, s_ready, s_dzo;
  logic [63:0] s_result;
  logic        f_busy, f_ready, f_dzo;
  logic [63:0] f_result;

  logic [63:0] s_cyc, s_cnt, s_bsy, s_res, s_dz;
  logic [63:0] f_cyc, f_cnt, f_bsy, f_res, f_dz;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32), .FAST_MUL(1'b0)) u_slow (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .op_i          (op),
    .a_i           (a),
    .b_i           (b),
    .cancel_i      (cancel),
    .busy_o        (s_busy),
    .ready_o       (s_ready),
    .result_o      (s_result),
    .div_by_zero_o (s_dzo)
  );

  muldiv_iter #(.WIDTH(32), .FAST_MUL(1'b1)) u_fast (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .op_i          (op),
    .a_i           (a),
    .b_i           (b),
    .cancel_i      (cancel),
    .busy_o        (f_busy),
    .ready_o       (f_ready),
    .result_o      (f_result),
    .div_by_zero_o (f_dzo)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clear_cap();
    s_cyc = '0; s_cnt = '0; s_bsy = '0; s_res = '0; s_dz = '0;
    f_cyc = '0; f_cnt = '0; f_bsy = '0; f_res = '0; f_dz = '0;
  endtask

  task automatic sample(input int c);
    if (s_ready) begin
      s_cnt = s_cnt + 64'd1;
      s_cyc = 64'(c);
      s_res = s_result;
      s_dz  = {63'd0, s_dzo};
    end
    if (s_busy) s_bsy = s_bsy + 64'd1;
    if (f_ready) begin
      f_cnt = f_cnt + 64'd1;
      f_cyc = 64'(c);
      f_res = f_result;
      f_dz  = {63'd0, f_dzo};
    end
    if (f_busy) f_bsy = f_bsy + 64'd1;
  endtask

  // start one op at edge 0, then watch cycles 1..40
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    clear_cap();
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      sample(c);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clear_cap();
    #1 rst = 1'b0;
    #2;
    check("rst_s_ctl", {61'd0, s_busy, s_ready, s_dzo}, 64'd0);
    check("rst_s_res", s_result, 64'd0);
    check("rst_f_ctl", {61'd0, f_busy, f_ready, f_dzo}, 64'd0);
    check("rst_f_res", f_result, 64'd0);
    #5 rst = 1'b1;

    run_op(OP_DIVU, 32'd100, 32'd7);
    check("divu_cnt", s_cnt, 64'd1);
    check("divu_lat", s_cyc, 64'd34);
    check("divu_busy", s_bsy, 64'd34);
    check("divu_res", s_res, 64'h00000002_0000000E);
    check("divu_dz", s_dz, 64'd0);
    check("divu_f_lat", f_cyc, 64'd34);
    check("divu_f_res", f_res, 64'h00000002_0000000E);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    check("div_neg_res", s_res, 64'hFFFFFFFF_FFFFFFFD);
    check("div_neg_f_res", f_res, 64'hFFFFFFFF_FFFFFFFD);

    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE);
    check("div_negb_res", s_res, 64'h00000001_FFFFFFFD);

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_res", s_res, 64'h00000000_80000000);
    check("div_ovf_f_res", f_res, 64'h00000000_80000000);

    run_op(OP_MULT, 32'hFFFFFFFF, 32'd2);
    check("mult_lat", s_cyc, 64'd34);
    check("mult_res", s_res, 64'hFFFFFFFF_FFFFFFFE);
    check("mult_f_cnt", f_cnt, 64'd1);
    check("mult_f_lat", f_cyc, 64'd3);
    check("mult_f_busy", f_bsy, 64'd3);
    check("mult_f_res", f_res, 64'hFFFFFFFF_FFFFFFFE);

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    check("multu_res", s_res, 64'h00000001_FFFFFFFE);
    check("multu_lat", s_cyc, 64'd34);
    check("multu_f_res", f_res, 64'h00000001_FFFFFFFE);
    check("multu_f_lat", f_cyc, 64'd3);

    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7);
    check("mult_m3x7", s_res, 64'hFFFFFFFF_FFFFFFEB);
    check("mult_f_m3x7", f_res, 64'hFFFFFFFF_FFFFFFEB);

    run_op(OP_DIV, 32'h12345678, 32'd0);
    check("dbz_lat", s_cyc, 64'd1);
    check("dbz_busy", s_bsy, 64'd1);
    check("dbz_flag", s_dz, 64'd1);
    check("dbz_res", s_res, 64'h12345678_FFFFFFFF);
    check("dbz_f_lat", f_cyc, 64'd1);
    check("dbz_f_flag", f_dz, 64'd1);

    // DIVU cancelled in cycle 10, with a stray start in cycle 5
    clear_cap();
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    for (int c = 1; c <= 10; c++) begin
      start  = (c == 5);
      op     = OP_MULT;
      a      = 32'd7;
      b      = 32'd7;
      cancel = (c == 10);
      @(negedge clk);
      sample(c);
      @(posedge clk); #1;
    end
    cancel = 1'b0;
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
    @(negedge clk);
    check("cancel_rdy", s_cnt + f_cnt, 64'd0);
    check("cancel_busy", {62'd0, s_busy, f_busy}, 64'd0);
    check("cancel_keep", s_result, 64'h12345678_FFFFFFFF);
    check("cancel_f_keep", f_result, 64'h12345678_FFFFFFFF);
    @(posedge clk); #1;
    start = 1'b0;
    clear_cap();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      sample(c);
      @(posedge clk); #1;
    end
    check("after_cnt", s_cnt, 64'd1);
    check("after_res", s_res, 64'd15);
    check("after_f_cnt", f_cnt, 64'd1);
    check("after_f_res", f_res, 64'd15);

    // reset in cycle 5 of a DIV
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("mrst_s_ctl", {61'd0, s_busy, s_ready, s_dzo}, 64'd0);
    check("mrst_s_res", s_result, 64'd0);
    check("mrst_f_ctl", {61'd0, f_busy, f_ready, f_dzo}, 64'd0);
    check("mrst_f_res", f_result, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(OP_DIVU, 32'd9, 32'd3);
    check("post_rst_cnt", s_cnt, 64'd1);
    check("post_rst_res", s_res, 64'h00000000_00000003);
    check("post_rst_f_res", f_res, 64'h00000000_00000003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit for the execute stage. It replaces the fixed 32-bit divider with one block that handles both operations. The block does signed and unsigned MULT/DIV at any operand width, one bit per cycle, with an optional single-cycle multiply path. It uses a start/ready handshake, and a cancel input lets a pipeline flush abort an operation in flight. The 2×WIDTH result feeds the HI/LO register write path.

## Interface

Parameters:
- WIDTH, default 32: operand width. Must be even and ≥ 4.
- FAST_MUL, default 0:
  - 1: multiply product is computed in one iteration cycle.
  - 0: shift-add multiply, one bit per cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  request. Sampled only in IDLE.
- op_i  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU. Sampled with start_i.
- a_i  in  WIDTH  multiplicand or dividend. Sampled with start_i.
- b_i  in  WIDTH  multiplier or divisor. Sampled with start_i.
- cancel_i  in  1  abort current operation (flush).
- busy_o  out  1  high in every state except IDLE.
- ready_o  out  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  out  2*WIDTH  multiply: {hi, lo} product. Divide: {remainder, quotient}.
- div_by_zero_o  out  1  high together with ready_o when the divide had b = 0.

## Operation

States: IDLE, MUL, DIV, FIX, DONE.

IDLE:
- start_i=1 and cancel_i=0: latch op, sign flags and absolute operand values (unsigned ops take operands as-is), then load iteration counter = WIDTH.
- op MUL*: go to MUL.
- op DIV* with b≠0: go to DIV.
- op DIV* with b=0: go to DONE, load result = {a_i, all ones} and set div_by_zero flag.

MUL:
- FAST_MUL=0: one shift-add step per cycle; counter decrements. At counter = 1, go to FIX.
- FAST_MUL=1: full unsigned product registered in one cycle, then go to FIX.

DIV:
- Restoring division, one quotient bit per cycle, MSB first.
- Partial remainder is WIDTH+1 bits wide.
- At counter = 1, go to FIX.

FIX (one cycle):
- Signed multiply: negate the 2×WIDTH product if the operand signs differ.
- Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- Go to DONE.

DONE: assert ready_o (and div_by_zero_o if flagged), then go to IDLE unconditionally.

Arithmetic rules:
- Quotient and product are modulo 2^WIDTH / 2^(2×WIDTH) in two's complement.
- Most-negative / −1 gives quotient = most-negative, remainder = 0. No trap.

Boundary conditions:
- start_i while busy_o=1 is ignored. There is no queueing.
- cancel_i=1 in any non-IDLE state: go to IDLE on the next edge. No ready_o pulse, and result_o keeps its previous value.
- cancel_i and start_i together in IDLE: cancel wins and nothing starts.
- result_o holds its value from DONE until the next DONE; internal scratch registers are separate.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values.

## Timing

- Reset values: busy_o=0, ready_o=0, result_o=0, div_by_zero_o=0, state=IDLE.
- Edge 0 is the edge that accepts start.
- Latency to the ready_o pulse, counted in cycles after edge 0:
  - DIV/DIVU, and MULT/MULTU with FAST_MUL=0: ready_o high in cycle WIDTH+2 (34 for WIDTH=32).
  - MULT/MULTU with FAST_MUL=1: cycle 3.
  - Divide by zero: cycle 1.
- busy_o is high from cycle 1 through the DONE cycle inclusive, and low in the cycle after DONE.
- A new start_i is accepted in the cycle after DONE, which gives back-to-back operation.
- ready_o is registered: no combinational path from any input to any output.

## Test plan

- DIVU, WIDTH=32, a=100, b=7 → ready_o only in cycle 34; result_o = {0x00000002, 0x0000000E}; div_by_zero_o=0.
- DIV, a=0xFFFFFFF9 (−7), b=2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- a=0xFFFFFFFF, b=2:
  - MULT → 0xFFFFFFFF_FFFFFFFE.
  - MULTU → 0x00000001_FFFFFFFE.
  - Repeat both with FAST_MUL=1 and check ready_o in cycle 3.
- DIV, a=0x12345678, b=0 → ready_o and div_by_zero_o in cycle 1; result_o = {0x12345678, 0xFFFFFFFF}.
- DIVU started with cancel_i pulsed in cycle 10:
  - Expect busy_o low in cycle 11, no ready_o, result_o unchanged.
  - A new MULTU 3×5 started in cycle 11 → exactly one ready_o, with result 15.
  - A start_i issued mid-operation is ignored.
- rst asserted low in cycle 5 of a DIV → all outputs 0 immediately. After release, DIVU 9/3 → {0, 3}.
